// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   state_t  : transmitter FSM states
//   PAR_*    : encodings accepted by the PARITY parameter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter.
//   ck       in  clock
//   rst      in  synchronous active-high reset
//   clear    in  restart the bit period on the next edge
//   bit_tick out high in the last ck cycle of each bit period
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic ck,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    // Free-running 0..CLKS_PER_BIT-1 counter; clear realigns it so the
    // start bit gets a full period.
    always_ff @(posedge ck) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO, one frame per byte.
//   ck         in  clock
//   rst        in  synchronous active-high reset
//   en         in  transmit enable, looked at only at decision points
//   Fempty     in  FIFO empty flag
//   Ren        out FIFO read strobe, one-cycle pulse
//   Din        in  FIFO read data, valid the cycle after Ren
//   txd        out serial line, idle high
//   busy       out high whenever the FSM is not idle
//   frame_done out pulse in the last cycle of the final stop bit
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       en,
    input  logic       Fempty,
    output logic       Ren,
    input  logic [7:0] Din,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic STOP_LAST = (STOP_BITS == 2);

    state_t     state;
    logic [7:0] shreg;
    logic       par_bit;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       bit_tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .ck      (ck),
        .rst     (rst),
        .clear   (state == LOAD),
        .bit_tick(bit_tick)
    );

    // txd is always loaded with the value of the bit about to start, so it
    // changes on the same edge as the state that owns that bit.
    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            Ren      <= 1'b0;
            busy     <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (en && !Fempty) begin
                        state <= FETCH;
                        Ren   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    Ren   <= 1'b0;
                    state <= LOAD;
                end
                LOAD: begin
                    shreg   <= Din;
                    par_bit <= (PARITY == PAR_ODD) ? ~^Din : ^Din;
                    bit_idx <= '0;
                    txd     <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_tick) begin
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            if (PARITY != PAR_NONE) begin
                                txd   <= par_bit;
                                state <= PAR;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                PAR: begin
                    if (bit_tick) begin
                        txd      <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_idx == STOP_LAST) begin
                            if (en && !Fempty) begin
                                state <= FETCH;
                                Ren   <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    Ren   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Decoded purely from registers, so there is no path from any input.
    assign frame_done = (state == STOP) && (stop_idx == STOP_LAST) && bit_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: three instances at CLKS_PER_BIT=4
// (no parity / 1 stop, even parity / 2 stop, odd parity / 1 stop), each with
// a FIFO model, a bit-level receiver and a byte scoreboard.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       ck = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic [2:0] ren;
    logic [2:0] txd;
    logic [2:0] busy;
    logic [2:0] frameDone;

    logic [7:0] fifoQ [3][$];
    logic [7:0] expQ  [3][$];

    int vecCount  = 0;
    int missCount = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 ck = ~ck;

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Writes a byte into an instance's FIFO and records it as expected output.
    task automatic applyStimulus(input int inst, input logic [7:0] b);
        fifoQ[inst].push_back(b);
        expQ[inst].push_back(b);
    endtask

    // Waits for an instance to drop busy, failing if it never does.
    task automatic waitIdle(input int inst, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge ck);
            if (busy[inst] == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput($sformatf("idle_timeout%0d", inst), 0, 1);
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int P     = i;
        localparam int S     = (i == 1) ? 2 : 1;
        localparam int NBITS = 9 + ((P != 0) ? 1 : 0) + S;

        logic       empty = 1'b1;
        logic [7:0] din;
        int         renCount = 0;
        int         renEmpty = 0;

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (P),
            .STOP_BITS   (S)
        ) dut (
            .ck        (ck),
            .rst       (rst),
            .en        (en[i]),
            .Fempty    (empty),
            .Ren       (ren[i]),
            .Din       (din),
            .txd       (txd[i]),
            .busy      (busy[i]),
            .frame_done(frameDone[i])
        );

        // FIFO read port: registered data after a strobe, junk otherwise so
        // that sampling Din in the wrong cycle shows up as a wrong byte.
        always @(posedge ck) begin
            if (ren[i] === 1'b1) begin
                renCount++;
                if (fifoQ[i].size() == 0) renEmpty++;
                else din <= fifoQ[i].pop_front();
            end else begin
                din <= 8'($urandom);
            end
        end

        // Empty flag follows the queue contents.
        always @(negedge ck) empty <= (fifoQ[i].size() == 0);

        // Samples one frame starting at its first start-bit cycle, then
        // measures the idle-high gap to a following back-to-back frame.
        task automatic receiveFrame(output bit nextStart);
            int          len;
            int          unstable;
            int          gap;
            bit          aborted;
            bit          sawNext;
            logic [11:0] obs;
            logic [11:0] expBits;
            logic [7:0]  b;
            nextStart = 1'b0;
            len       = 0;
            unstable  = 0;
            aborted   = 1'b0;
            obs       = '1;
            forever begin
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (len < NBITS * CPB) begin
                    if (len % CPB == 0) obs[len / CPB] = txd[i];
                    else if (txd[i] !== obs[len / CPB]) unstable++;
                end
                len++;
                if (frameDone[i] === 1'b1 || len >= 100) break;
                @(negedge ck);
            end
            if (aborted) return;
            checkOutput($sformatf("frame_len%0d", i), len, NBITS * CPB);
            checkOutput($sformatf("bit_stable%0d", i), unstable, 0);
            if (expQ[i].size() == 0) begin
                checkOutput($sformatf("unexpected_frame%0d", i), 1, 0);
                return;
            end
            b          = expQ[i].pop_front();
            expBits    = '1;
            expBits[0] = 1'b0;
            expBits[8:1] = b;
            if (P == 1) expBits[9] = ^b;
            if (P == 2) expBits[9] = ~^b;
            checkOutput($sformatf("frame_bits%0d", i), int'(obs), int'(expBits));
            gap     = 0;
            sawNext = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge ck);
                if (rst || busy[i] !== 1'b1) begin
                    sawNext = 1'b1;
                    break;
                end
                if (txd[i] === 1'b0) begin
                    checkOutput($sformatf("gap%0d", i), gap, 2);
                    nextStart = 1'b1;
                    sawNext   = 1'b1;
                    break;
                end
                gap++;
            end
            if (!sawNext) checkOutput($sformatf("gap_timeout%0d", i), gap, 2);
        endtask

        // Receiver loop: looks for a low line outside reset each cycle.
        initial begin : rx
            bit pending;
            pending = 1'b0;
            forever begin
                if (!pending) @(negedge ck);
                pending = 1'b0;
                if (!rst && txd[i] === 1'b0) receiveFrame(pending);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, guards, single frame, enable drop, reset mid-frame,
    // parity, back-to-back, and a throughput run against a filling FIFO.
    initial begin
        int pushed;
        rst = 1'b1;
        en  = 3'b000;
        repeat (3) @(posedge ck);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_txd%0d", i), txd[i], 1);
            checkOutput($sformatf("reset_busy%0d", i), busy[i], 0);
            checkOutput($sformatf("reset_ren%0d", i), ren[i], 0);
            checkOutput($sformatf("reset_done%0d", i), frameDone[i], 0);
        end
        @(negedge ck);
        rst = 1'b0;

        en[0] = 1'b1;
        repeat (20) @(negedge ck);
        checkOutput("ren_on_empty", g[0].renCount, 0);
        en[0] = 1'b0;
        applyStimulus(0, 8'hA5);
        repeat (20) @(negedge ck);
        checkOutput("ren_when_disabled", g[0].renCount, 0);
        checkOutput("busy_when_disabled", busy[0], 0);

        en[0] = 1'b1;
        @(posedge ck);
        #1;
        checkOutput("ren_pulse", ren[0], 1);
        checkOutput("busy_start", busy[0], 1);
        @(posedge ck);
        #1;
        checkOutput("ren_one_cycle", ren[0], 0);
        waitIdle(0, 200);
        checkOutput("ren_count_a5", g[0].renCount, 1);

        applyStimulus(0, 8'h3C);
        fifoQ[0].push_back(8'h5A);
        repeat (10) @(negedge ck);
        en[0] = 1'b0;
        waitIdle(0, 200);
        repeat (10) @(negedge ck);
        checkOutput("en_drop_ren", g[0].renCount, 2);
        checkOutput("en_drop_idle", busy[0], 0);

        expQ[0].push_back(8'h5A);
        en[0] = 1'b1;
        repeat (15) @(negedge ck);
        checkOutput("busy_before_reset", busy[0], 1);
        rst = 1'b1;
        @(posedge ck);
        #1;
        checkOutput("midreset_txd", txd[0], 1);
        checkOutput("midreset_busy", busy[0], 0);
        checkOutput("midreset_ren", ren[0], 0);
        repeat (2) @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
        void'(expQ[0].pop_front());
        repeat (20) @(negedge ck);
        checkOutput("post_reset_ren", g[0].renCount, 3);
        checkOutput("post_reset_txd", txd[0], 1);
        en[0] = 1'b0;

        applyStimulus(1, 8'h07);
        applyStimulus(2, 8'h07);
        en[2:1] = 2'b11;
        repeat (5) @(negedge ck);
        waitIdle(1, 200);
        waitIdle(2, 200);
        checkOutput("parity_ren1", g[1].renCount, 1);
        checkOutput("parity_ren2", g[2].renCount, 1);

        applyStimulus(1, 8'h01);
        applyStimulus(1, 8'h02);
        applyStimulus(1, 8'h03);
        repeat (5) @(negedge ck);
        waitIdle(1, 600);
        checkOutput("b2b_ren", g[1].renCount, 4);
        checkOutput("b2b_drained", expQ[1].size(), 0);

        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 24; c++) begin
            @(negedge ck);
            if (fifoQ[2].size() < 16) begin
                applyStimulus(2, 8'($urandom));
                pushed++;
            end
        end
        checkOutput("writer_pushed", pushed, 24);
        waitIdle(2, 1500);
        repeat (10) @(negedge ck);
        checkOutput("thru_ren", g[2].renCount, 25);
        checkOutput("thru_drained", expQ[2].size(), 0);

        checkOutput("ren_empty0", g[0].renEmpty, 0);
        checkOutput("ren_empty1", g[1].renEmpty, 0);
        checkOutput("ren_empty2", g[2].renEmpty, 0);
        checkOutput("sb_left0", expQ[0].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
